// File: rtl/mul_arb_seq_if.sv
// rtl/mul_arb_seq_if.sv - request/grant and datapath control bundle for mul_arb_seq
interface mul_arb_seq_if;
  logic       req0;
  logic       req1;
  logic       gnt0;
  logic       gnt1;
  logic       done0;
  logic       done1;
  logic       busy;
  logic       sel_op;
  logic       ld_op;
  logic [1:0] a_sel;
  logic       b_sel;
  logic [5:0] shift_val;
  logic       upd_prod;
  logic       clr_prod;

  // Requesters drive req and observe grants/dones.
  modport master (
    output req0, req1,
    input  gnt0, gnt1, done0, done1, busy,
    input  sel_op, ld_op, a_sel, b_sel, shift_val, upd_prod, clr_prod
  );

  // The sequencer sees requests and drives everything else.
  modport slave (
    input  req0, req1,
    output gnt0, gnt1, done0, done1, busy,
    output sel_op, ld_op, a_sel, b_sel, shift_val, upd_prod, clr_prod
  );
endinterface

// File: rtl/mul_arb_seq.sv
// rtl/mul_arb_seq.sv - two-requester arbiter and 8-step partial-product sequencer
module mul_arb_seq #(
  parameter bit PRIO_RR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  mul_arb_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0] state;
  logic [2:0] k;
  logic       last;
  logic       owner;
  logic       winner;
  logic       any_req;

  assign any_req = bus.req0 | bus.req1;

  // Contention goes to whoever did not win last time (round-robin) or to requester 0.
  always_comb begin
    winner = 1'b0;
    if (bus.req0 && bus.req1) begin
      if (PRIO_RR)
        winner = ~last;
      else
        winner = 1'b0;
    end else begin
      winner = bus.req1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      k     <= 3'd0;
      last  <= 1'b1;
      owner <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner <= winner;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          k     <= 3'd0;
          state <= S_CALC;
        end
        S_CALC: begin
          k <= k + 3'd1;
          if (k == 3'd7)
            state <= S_DONE;
        end
        S_DONE: begin
          last  <= owner;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic in_load;
  logic in_calc;
  logic in_done;
  logic active;

  assign in_load = (state == S_LOAD);
  assign in_calc = (state == S_CALC);
  assign in_done = (state == S_DONE);
  assign active  = (state != S_IDLE);

  assign bus.busy     = active;
  assign bus.gnt0     = active & ~owner;
  assign bus.gnt1     = active & owner;
  assign bus.sel_op   = active & owner;
  assign bus.done0    = in_done & ~owner;
  assign bus.done1    = in_done & owner;
  assign bus.ld_op    = in_load;
  assign bus.clr_prod = in_load;
  assign bus.upd_prod = in_calc;

  // Step k walks B halves fastest, then A bytes; shift is 8*a_sel + 16*b_sel.
  assign bus.a_sel     = in_calc ? k[2:1] : 2'd0;
  assign bus.b_sel     = in_calc & k[0];
  assign bus.shift_val = in_calc ? ({1'b0, k[2:1], 3'b000} + {1'b0, k[0], 4'b0000}) : 6'd0;

endmodule

// File: tb/tb_mul_arb_seq.sv
// tb/tb_mul_arb_seq.sv - self-checking bench for mul_arb_seq (both arbitration modes)
module tb_mul_arb_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   gcyc = 0;
  int   t0 = 0;
  bit   chk_en = 1'b0;
  int   done_q0[$];
  int   done_q1[$];

  always #5 clk = ~clk;

  mul_arb_seq_if bus_rr ();
  mul_arb_seq_if bus_fp ();

  assign bus_rr.req0 = req0;
  assign bus_rr.req1 = req1;
  assign bus_fp.req0 = req0;
  assign bus_fp.req1 = req1;

  mul_arb_seq #(.PRIO_RR(1'b1)) u_rr (.clk(clk), .rst(rst), .bus(bus_rr));
  mul_arb_seq #(.PRIO_RR(1'b0)) u_fp (.clk(clk), .rst(rst), .bus(bus_fp));

  logic [17:0] obs [2];
  assign obs[0] = {bus_rr.gnt0, bus_rr.gnt1, bus_rr.done0, bus_rr.done1, bus_rr.busy, bus_rr.sel_op,
                   bus_rr.ld_op, bus_rr.a_sel, bus_rr.b_sel, bus_rr.shift_val, bus_rr.upd_prod, bus_rr.clr_prod};
  assign obs[1] = {bus_fp.gnt0, bus_fp.gnt1, bus_fp.done0, bus_fp.done1, bus_fp.busy, bus_fp.sel_op,
                   bus_fp.ld_op, bus_fp.a_sel, bus_fp.b_sel, bus_fp.shift_val, bus_fp.upd_prod, bus_fp.clr_prod};

  // Model: an operation is 10 cycles (LOAD, 8 steps, DONE); m_ph is the cycle index, -1 when idle.
  int   m_ph  [2];
  logic m_own [2];
  logic m_last[2];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_ph[i]   <= -1;
        m_own[i]  <= 1'b0;
        m_last[i] <= 1'b1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_ph[i] < 0) begin
          if (req0 || req1) begin
            if (req0 && req1) m_own[i] <= (i == 0) ? ~m_last[i] : 1'b0;
            else              m_own[i] <= req1;
            m_ph[i] <= 0;
          end
        end else if (m_ph[i] == 9) begin
          m_last[i] <= m_own[i];
          m_ph[i]   <= -1;
        end else begin
          m_ph[i] <= m_ph[i] + 1;
        end
      end
    end
  end

  always @(posedge clk) gcyc <= gcyc + 1;

  function automatic logic [17:0] exp_vec(int ph, logic own);
    logic g0, g1, d0, d1, bz, so, ld, bs, up, cl;
    logic [1:0] as;
    logic [5:0] sh;
    int s;
    {g0, g1, d0, d1, bz, so, ld, bs, up, cl} = '0;
    as = '0;
    sh = '0;
    s  = 0;
    if (ph >= 0) begin
      bz = 1'b1; so = own; g0 = ~own; g1 = own;
    end
    if (ph == 0) begin
      ld = 1'b1; cl = 1'b1;
    end
    if (ph >= 1 && ph <= 8) begin
      s  = ph - 1;
      as = 2'(s / 2);
      bs = 1'(s % 2);
      sh = 6'(8 * (s / 2) + 16 * (s % 2));
      up = 1'b1;
    end
    if (ph == 9) begin
      d0 = ~own; d1 = own;
    end
    return {g0, g1, d0, d1, bz, so, ld, as, bs, sh, up, cl};
  endfunction

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, gcyc - t0);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs[i] !== exp_vec(m_ph[i], m_own[i])) begin
          miscompares++;
          $display("FAIL model inst%0d: got %h expected %h (cycle %0d)", i, obs[i], exp_vec(m_ph[i], m_own[i]), gcyc - t0);
        end
        vectors++;
        if (obs[i][17] && obs[i][16]) begin
          miscompares++;
          $display("FAIL gnt_excl inst%0d: gnt0=1 gnt1=1 required not both", i);
        end
      end
      if (obs[0][15]) done_q0.push_back((gcyc - t0) * 2);
      if (obs[0][14]) done_q0.push_back((gcyc - t0) * 2 + 1);
      if (obs[1][15]) done_q1.push_back((gcyc - t0) * 2);
      if (obs[1][14]) done_q1.push_back((gcyc - t0) * 2 + 1);
    end
  end

  task automatic start(logic r0, logic r1);
    @(negedge clk);
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; req0 = r0; req1 = r1;
    t0 = gcyc;
    done_q0.delete();
    done_q1.delete();
  endtask

  int sh_tab [8] = '{0, 16, 8, 24, 16, 32, 24, 40};
  int gnt1_fp;

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_outputs_rr", int'(obs[0]), 0);
    chk("reset_outputs_fp", int'(obs[1]), 0);

    // Single requester 0 held: full sequence with literal timing.
    start(1'b1, 1'b0);
    for (int n = 0; n <= 11; n++) begin
      if (n > 0) @(negedge clk);
      chk("s1_gnt0", int'(bus_rr.gnt0), (n >= 1 && n <= 10) ? 1 : 0);
      chk("s1_busy", int'(bus_rr.busy), (n >= 1 && n <= 10) ? 1 : 0);
      chk("s1_ld_clr", int'({bus_rr.ld_op, bus_rr.clr_prod}), (n == 1) ? 3 : 0);
      chk("s1_upd", int'(bus_rr.upd_prod), (n >= 2 && n <= 9) ? 1 : 0);
      chk("s1_shift", int'(bus_rr.shift_val), (n >= 2 && n <= 9) ? sh_tab[n - 2] : 0);
      chk("s1_done0", int'(bus_rr.done0), (n == 10) ? 1 : 0);
      if (n == 10) req0 = 1'b0;
    end

    // Both held: round-robin alternates, fixed priority always serves 0.
    start(1'b1, 1'b1);
    gnt1_fp = 0;
    for (int n = 0; n <= 33; n++) begin
      if (n > 0) @(negedge clk);
      if (bus_fp.gnt1) gnt1_fp++;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("s2_rr_count", done_q0.size(), 3);
    chk("s2_fp_count", done_q1.size(), 3);
    if (done_q0.size() == 3) begin
      chk("s2_rr_done_a", done_q0[0], 20);
      chk("s2_rr_done_b", done_q0[1], 43);
      chk("s2_rr_done_c", done_q0[2], 64);
    end
    if (done_q1.size() == 3) begin
      chk("s2_fp_done_a", done_q1[0], 20);
      chk("s2_fp_done_b", done_q1[1], 42);
      chk("s2_fp_done_c", done_q1[2], 64);
    end
    chk("s2_fp_gnt1_cycles", gnt1_fp, 0);

    // Request dropped mid-CALC still completes.
    start(1'b1, 1'b0);
    for (int n = 0; n <= 12; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 4) req0 = 1'b0;
    end
    chk("s3_done_count", done_q0.size(), 1);
    if (done_q0.size() == 1) chk("s3_done0_at", done_q0[0], 20);

    // Reset during step k=4 aborts without a done; arbitration restarts.
    start(1'b0, 1'b1);
    for (int n = 1; n <= 6; n++) @(negedge clk);
    chk("s4_pre_gnt1", int'(bus_rr.gnt1), 1);
    rst = 1'b0;
    #1;
    chk("s4_rst_out_rr", int'(obs[0]), 0);
    chk("s4_rst_out_fp", int'(obs[1]), 0);
    repeat (2) @(negedge clk);
    chk("s4_no_done", done_q0.size() + done_q1.size(), 0);
    rst = 1'b1;
    t0 = gcyc;
    chk("s4_idle_gnt1", int'(bus_rr.gnt1), 0);
    @(negedge clk);
    chk("s4_restart_gnt1", int'(bus_rr.gnt1), 1);
    repeat (10) @(negedge clk);
    req1 = 1'b0;

    // Single-cycle req1 pulse.
    start(1'b0, 1'b1);
    @(negedge clk);
    req1 = 1'b0;
    repeat (11) @(negedge clk);
    chk("s5_done_count", done_q0.size(), 1);
    if (done_q0.size() == 1) chk("s5_done1_at", done_q0[0], 21);

    // Random traffic with occasional asynchronous resets, checked by the model.
    start(1'b0, 1'b0);
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 120) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
